// File: rtl/mbist_addr_counter.sv
// Windowed up/down address sequencer for the MBIST march engine.
// Optional Gray-coded address output when ADDR_CNT_GRAY_EN is defined.
module mbist_addr_counter #(
    parameter int unsigned LENGTH      = 10,
    parameter int unsigned SWEEP_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cen,
    input  logic                   ld,
    input  logic                   u_d,
    input  logic [LENGTH-1:0]      d_in,
    input  logic [LENGTH-1:0]      lo,
    input  logic [LENGTH-1:0]      hi,
    input  logic                   wrap_en,
    output logic [LENGTH-1:0]      q,
    output logic                   cout,
    output logic                   done,
    output logic [SWEEP_WIDTH-1:0] sweep_cnt
`ifdef ADDR_CNT_GRAY_EN
    ,
    output logic [LENGTH-1:0]      q_gray
`endif
);

    logic [LENGTH-1:0]      q_q, q_d;
    logic                   done_q, done_d;
    logic [SWEEP_WIDTH-1:0] sweep_q, sweep_d;
    logic                   at_hi, at_lo, at_bound;

    assign at_hi    = (q_q >= hi);
    assign at_lo    = (q_q <= lo);
    assign at_bound = u_d ? at_hi : at_lo;

    always_comb begin
        q_d     = q_q;
        done_d  = done_q;
        sweep_d = sweep_q;
        cout    = cen & ~ld & at_bound;
        if (cen) begin
            if (ld) begin
                q_d    = d_in;
                done_d = 1'b0;
            end else if (!at_bound) begin
                q_d = u_d ? q_q + LENGTH'(1) : q_q - LENGTH'(1);
            end else if (wrap_en) begin
                // Wrap lands on the opposite bound, never modulo 2^LENGTH.
                q_d = u_d ? lo : hi;
                if (sweep_q != {SWEEP_WIDTH{1'b1}}) begin
                    sweep_d = sweep_q + SWEEP_WIDTH'(1);
                end
            end else begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q     <= '0;
            done_q  <= 1'b0;
            sweep_q <= '0;
        end else begin
            q_q     <= q_d;
            done_q  <= done_d;
            sweep_q <= sweep_d;
        end
    end

    assign q         = q_q;
    assign done      = done_q;
    assign sweep_cnt = sweep_q;

`ifdef ADDR_CNT_GRAY_EN
    assign q_gray = q_q ^ (q_q >> 1);
`endif

endmodule

// File: tb/tb_mbist_addr_counter.sv
// Directed table-driven bench for mbist_addr_counter (LENGTH=10, SWEEP_WIDTH=4).
module tb_mbist_addr_counter;

    logic       clk = 1'b0;
    logic       rst, cen, ld, u_d, wrap_en;
    logic [9:0] d_in, lo, hi;
    logic [9:0] q;
    logic       cout, done;
    logic [3:0] sweep_cnt;
`ifdef ADDR_CNT_GRAY_EN
    logic [9:0] q_gray;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mbist_addr_counter #(.LENGTH(10), .SWEEP_WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .ld        (ld),
        .u_d       (u_d),
        .d_in      (d_in),
        .lo        (lo),
        .hi        (hi),
        .wrap_en   (wrap_en),
        .q         (q),
        .cout      (cout),
        .done      (done),
        .sweep_cnt (sweep_cnt)
`ifdef ADDR_CNT_GRAY_EN
        ,
        .q_gray    (q_gray)
`endif
    );

    typedef struct {
        logic       rst, cen, ld, u_d, wrap_en;
        logic [9:0] d_in, lo, hi;
        logic       exp_cout;  // sampled before the edge
        logic [9:0] exp_q;     // after the edge
        logic       exp_done;
        logic [3:0] exp_sweep;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic c, logic l, logic ud, logic [9:0] d,
                                logic [9:0] l_b, logic [9:0] h_b, logic w,
                                logic ec, logic [9:0] eq, logic ed, logic [3:0] es);
        vec_t v;
        v.rst = r; v.cen = c; v.ld = l; v.u_d = ud; v.d_in = d;
        v.lo = l_b; v.hi = h_b; v.wrap_en = w;
        v.exp_cout = ec; v.exp_q = eq; v.exp_done = ed; v.exp_sweep = es;
        return v;
    endfunction

    task automatic check(string name, int idx, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, got, exp);
        end
    endtask

    task automatic apply(vec_t v, int idx);
        @(negedge clk);
        rst = v.rst; cen = v.cen; ld = v.ld; u_d = v.u_d; d_in = v.d_in;
        lo = v.lo; hi = v.hi; wrap_en = v.wrap_en;
        #1;
        check("cout", idx, 32'(cout), 32'(v.exp_cout));
        @(posedge clk);
        #1;
        check("q", idx, 32'(q), 32'(v.exp_q));
        check("done", idx, 32'(done), 32'(v.exp_done));
        check("sweep_cnt", idx, 32'(sweep_cnt), 32'(v.exp_sweep));
    endtask

    initial begin
        rst = 1'b0; cen = 1'b0; ld = 1'b0; u_d = 1'b0; wrap_en = 1'b0;
        d_in = '0; lo = '0; hi = '0;

        //             rst cen ld ud d_in    lo      hi      wr  cout q       dn  sw
        vecs.push_back(mk(1, 0, 0, 0, 10'h000, 10'h000, 10'h000, 0, 0, 10'h000, 0, 4'd0));
        vecs.push_back(mk(0, 1, 1, 0, 10'h155, 10'h000, 10'h3FF, 0, 0, 10'h155, 0, 4'd0));
        vecs.push_back(mk(0, 0, 1, 0, 10'h2AA, 10'h000, 10'h3FF, 0, 0, 10'h155, 0, 4'd0));
        // Up-count wrap inside [0x010, 0x013]
        vecs.push_back(mk(0, 1, 1, 1, 10'h010, 10'h010, 10'h013, 1, 0, 10'h010, 0, 4'd0));
        vecs.push_back(mk(0, 1, 0, 1, 10'h000, 10'h010, 10'h013, 1, 0, 10'h011, 0, 4'd0));
        vecs.push_back(mk(0, 1, 0, 1, 10'h000, 10'h010, 10'h013, 1, 0, 10'h012, 0, 4'd0));
        vecs.push_back(mk(0, 1, 0, 1, 10'h000, 10'h010, 10'h013, 1, 0, 10'h013, 0, 4'd0));
        vecs.push_back(mk(0, 1, 0, 1, 10'h000, 10'h010, 10'h013, 1, 1, 10'h010, 0, 4'd1));
        // Down-count wrap from lo to hi
        vecs.push_back(mk(0, 1, 0, 0, 10'h000, 10'h010, 10'h013, 1, 1, 10'h013, 0, 4'd2));
        vecs.push_back(mk(0, 1, 0, 0, 10'h000, 10'h010, 10'h013, 1, 0, 10'h012, 0, 4'd2));
        // Direction reversal mid-sweep
        vecs.push_back(mk(0, 1, 0, 1, 10'h000, 10'h010, 10'h013, 1, 0, 10'h013, 0, 4'd2));
        // Stop mode at top of full range, sticky done
        vecs.push_back(mk(0, 1, 1, 1, 10'h3FE, 10'h000, 10'h3FF, 0, 0, 10'h3FE, 0, 4'd2));
        vecs.push_back(mk(0, 1, 0, 1, 10'h000, 10'h000, 10'h3FF, 0, 0, 10'h3FF, 0, 4'd2));
        vecs.push_back(mk(0, 1, 0, 1, 10'h000, 10'h000, 10'h3FF, 0, 1, 10'h3FF, 1, 4'd2));
        vecs.push_back(mk(0, 1, 0, 1, 10'h000, 10'h000, 10'h3FF, 0, 1, 10'h3FF, 1, 4'd2));
        vecs.push_back(mk(0, 1, 0, 0, 10'h000, 10'h000, 10'h3FF, 0, 0, 10'h3FE, 1, 4'd2));
        vecs.push_back(mk(0, 0, 0, 1, 10'h000, 10'h000, 10'h3FF, 0, 0, 10'h3FE, 1, 4'd2));
        vecs.push_back(mk(0, 1, 1, 0, 10'h005, 10'h000, 10'h3FF, 0, 0, 10'h005, 0, 4'd2));
        vecs.push_back(mk(0, 1, 0, 0, 10'h000, 10'h005, 10'h3FF, 0, 1, 10'h005, 1, 4'd2));
        // lo=0 down-count wraps to hi, not all-ones
        vecs.push_back(mk(0, 1, 1, 0, 10'h000, 10'h000, 10'h007, 1, 0, 10'h000, 0, 4'd2));
        vecs.push_back(mk(0, 1, 0, 0, 10'h000, 10'h000, 10'h007, 1, 1, 10'h007, 0, 4'd3));
        // Degenerate window lo==hi
        vecs.push_back(mk(0, 1, 1, 1, 10'h020, 10'h020, 10'h020, 1, 0, 10'h020, 0, 4'd3));

        foreach (vecs[i]) apply(vecs[i], i);

        // lo==hi with wrap: sweep_cnt saturates at 0xF while q stays put
        for (int k = 1; k <= 20; k++) begin
            int es;
            es = (3 + k > 15) ? 15 : 3 + k;
            apply(mk(0, 1, 0, (k % 2 == 0), 10'h000, 10'h020, 10'h020, 1,
                     1, 10'h020, 0, 4'(es)), 100 + k);
        end

        // Stop to set done, then reset beats an active load
        apply(mk(0, 1, 0, 1, 10'h000, 10'h020, 10'h020, 0, 1, 10'h020, 1, 4'd15), 200);
        apply(mk(1, 1, 1, 1, 10'h155, 10'h020, 10'h020, 0, 0, 10'h000, 0, 4'd0), 201);

`ifdef ADDR_CNT_GRAY_EN
        #1;
        check("q_gray_rst", 202, 32'(q_gray), 32'h0);
        apply(mk(0, 1, 1, 1, 10'h155, 10'h000, 10'h3FF, 0, 0, 10'h155, 0, 4'd0), 203);
        check("q_gray", 203, 32'(q_gray), 32'h1FF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
